// File: rtl/add_n_pkg.sv
// Shared constants for the digit-serial adder: FSM state encodings and counter sizing.
package add_n_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Digit counter needs at least one bit even when a single slice covers the word.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/add_digit.sv
// DIGIT-bit ripple adder built from full_adder cells; combinational, no backpressure.
module add_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;
  assign cout = c[DIGIT];

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .x    (x[i]),
      .y    (y[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell; purely combinational.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/add_n_serial.sv
// Digit-serial add/sub, LSB first: done pulses WIDTH/DIGIT+1 cycles after start is accepted.
// start is taken only while ready is high; requests during RUN/DONE are dropped, not queued.
module add_n_serial
  import add_n_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] out_q;
  logic             cy;
  logic             ovf_q;
  logic             last;
  logic [DIGIT-1:0] slice_s;
  logic             slice_c;

  assign last = (cnt == CW'(N - 1));

  // Single digit adder shared across all slices; the counter selects which slice feeds it.
  add_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (op_a[cnt*DIGIT +: DIGIT]),
    .y    (op_b[cnt*DIGIT +: DIGIT]),
    .cin  (cy),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      out_q <= '0;
      cy    <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert b once here and seed the carry with sub.
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            cy    <= sub;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          out_q[cnt*DIGIT +: DIGIT] <= slice_s;
          cy  <= slice_c;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last) begin
            ovf_q <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (slice_s[DIGIT-1] != op_a[WIDTH-1]);
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready    = (state == ST_IDLE);
  assign done     = (state == ST_DONE);
  assign out      = out_q;
  assign carry    = cy;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_add_n_serial.sv
// Drives three add_n_serial instances (DIGIT=4, 1, 16) against a scoreboard of expected results.
module tb_add_n_serial;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] out;
    logic         c;
    logic         v;
    int           acc;
    int           lat;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] o;
    logic         c;
    logic         v;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   start = '0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   ready, done, carry, ovf;
  logic [W-1:0] out [3];

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done0_cnt;
  exp_t q0[$], q1[$], q2[$];
  vec_t vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int DG = (i == 0) ? 4 : ((i == 1) ? 1 : 16);
    add_n_serial #(.WIDTH(W), .DIGIT(DG)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[i]),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .ready    (ready[i]),
      .done     (done[i]),
      .out      (out[i]),
      .carry    (carry[i]),
      .overflow (ovf[i])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int nsl(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 16 : 1);
  endfunction

  function automatic void push(input int d, input exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : ((d == 1) ? q1.size() : q2.size());
  endfunction

  function automatic exp_t pop(input int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst_n && done[i]) begin
        if (qsize(i) == 0) begin
          chk($sformatf("spurious_done_d%0d", i), 1, 0);
        end else begin
          e = pop(i);
          chk($sformatf("out_d%0d", i), out[i], e.out);
          chk($sformatf("carry_d%0d", i), carry[i], e.c);
          chk($sformatf("ovf_d%0d", i), ovf[i], e.v);
          chk($sformatf("latency_d%0d", i), cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic run_op(input int d, input vec_t v, input bit hold);
    int n;
    exp_t e;
    n = 0;
    while (!ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready[d]) begin
      chk($sformatf("ready_timeout_d%0d", d), 0, 1);
      return;
    end
    a = v.a;
    b = v.b;
    sub = v.s;
    start[d] = 1'b1;
    e = '{v.o, v.c, v.v, cyc + 1, nsl(d)};
    push(d, e);
    @(negedge clk);
    chk($sformatf("ready_low_d%0d", d), ready[d], 0);
    if (!hold) start[d] = 1'b0;
    n = 0;
    // Operands keep changing after acceptance; with hold, start also stays high.
    while (!done[d] && n < 50) begin
      a = W'($urandom);
      b = W'($urandom);
      sub = 1'($urandom);
      @(negedge clk);
      n++;
    end
    if (!done[d]) chk($sformatf("done_timeout_d%0d", d), 0, 1);
    start[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("ready_back_d%0d", d), ready[d], 1);
    chk($sformatf("done_single_d%0d", d), done[d], 0);
    chk($sformatf("out_held_d%0d", d), out[d], v.o);
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[1] = '{16'h3CC3, 16'h0FF0, 1'b0, 16'h4CB3, 1'b0, 1'b0};
    vecs[2] = '{16'h1234, 16'h9876, 1'b0, 16'hAAAA, 1'b0, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[5] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready_d%0d", i), ready[i], 1);
      chk($sformatf("rst_done_d%0d", i), done[i], 0);
      chk($sformatf("rst_out_d%0d", i), out[i], 0);
      chk($sformatf("rst_carry_d%0d", i), carry[i], 0);
      chk($sformatf("rst_ovf_d%0d", i), ovf[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 7; k++)
        run_op(d, vecs[k], 1'b0);

    // start held high throughout RUN/DONE must yield exactly one result.
    run_op(0, vecs[1], 1'b1);
    run_op(0, vecs[6], 1'b1);

    // Reset in the second RUN cycle aborts the operation.
    a = 16'h1234;
    b = 16'h9876;
    sub = 1'b0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    chk("run_before_rst", ready[0], 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ready", ready[0], 1);
    chk("abort_out", out[0], 0);
    chk("abort_carry", carry[0], 0);
    chk("abort_ovf", ovf[0], 0);
    chk("abort_done", done[0], 0);
    rst_n = 1'b1;
    done0_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done[0]) done0_cnt++;
    end
    chk("no_done_after_abort", done0_cnt, 0);

    run_op(0, vecs[2], 1'b0);

    for (int d = 0; d < 3; d++)
      chk($sformatf("sb_empty_d%0d", d), qsize(d), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_n_serial.md
Name: add_n_serial

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the fixed 16-bit combinational adder.
- Processes operands LSB-first, DIGIT bits per clock, with a registered carry between digits.
- Start/done handshake, subtract mode, carry and overflow flags.
- Sits in the ALU datapath where a narrow, low-area adder is preferred over a full-width ripple chain.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 1.
- DIGIT, 4, bits processed per cycle; must divide WIDTH. Let N = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted only when ready=1
- sub  input  1  0: out=a+b; 1: out=a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse; out/carry/overflow valid
- out  output  WIDTH  result; held until next accepted start
- carry  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, ready=1, done=0, out=0, carry=0, overflow=0.
  - Takes priority over every other event. Aborts any operation in flight; no done pulse follows.
- FSM states: IDLE, RUN, DONE.
  - IDLE: at an edge with start=1, latch a, b^{WIDTH{sub}} and sub (initial carry-in = sub). Clear the digit counter and go to RUN. ready drops in the following cycle.
  - RUN: each edge adds the current DIGIT-wide slice plus the carry register. It writes the slice sum into out[digit], updates the carry register and increments the counter. After the N-th slice edge, go to DONE.
  - DONE: done=1, ready=0 for exactly one cycle, then IDLE.
- Latency: start accepted at edge k -> done high in the cycle after edge k+N. Next start accepted at edge k+N+2 at the earliest.
- start while RUN/DONE: ignored, no queuing. Input changes after acceptance have no effect.
- out is undefined-free: partially updated slices are visible during RUN, but only the done cycle defines the result. Previous result bits are overwritten slice by slice.
- carry: final carry register value.
- overflow: (a_msb == b'_msb) && (out_msb != a_msb), where b' is the inverted b when sub=1.
- Width rules: all arithmetic is mod 2^WIDTH. No sign extension.
- DIGIT == WIDTH (N=1): one RUN cycle. Counter width is max(1, clog2(N)).

Decomposition:
- Shared package add_n_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Helper function for counter width (clog2).
- One natural sub-module: add_digit. It is a combinational DIGIT-bit ripple adder: inputs x, y, cin; outputs s and cout. It is built from the existing full-adder cell and instantiated once, with operand slices muxed by the digit counter.

Test Plan:
- WIDTH=16, DIGIT=4, sub=0, a=0000, b=FFFF -> done 5 cycles after start edge. out=FFFF, carry=0, overflow=0, ready back 1 cycle later.
- a=3CC3, b=0FF0, sub=0 -> out=4CB3, carry=0. Then a=1234, b=9876 -> out=AAAA, carry=0, overflow=0.
- a=FFFF, b=0001 -> out=0000, carry=1. Then a=7FFF, b=0001 -> out=8000, carry=0, overflow=1.
- sub=1, a=0005, b=0007 -> out=FFFE, carry=0. Then sub=1, a=8000, b=0001 -> out=7FFF, overflow=1, carry=1.
- Assert start every cycle during RUN with different operands -> ignored. Exactly one done per accepted start, and the result matches the first operands.
  - Then pull rst_n low at RUN cycle 2 -> next cycle ready=1, out=0, no done pulse.
- Re-run vectors 1–4 with DIGIT=1 (done after 17 cycles) and DIGIT=16 (done after 2 cycles) -> identical results and flags.
